// File: rtl/regfile_mp.sv
// Multi-port integer register file with a one-bit-per-register busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle writes onto the read ports.
module regfile_mp #(
  parameter int XLEN      = 32,
  parameter int NUM_REGS  = 16,
  parameter int NUM_READ  = 2,
  parameter int NUM_WRITE = 1,
  parameter int AW        = $clog2(NUM_REGS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_READ*AW-1:0]    rs_addr,
  output logic [NUM_READ*XLEN-1:0]  rs_data,
  output logic [NUM_READ-1:0]       rs_busy,
  input  logic [NUM_WRITE-1:0]      we,
  input  logic [NUM_WRITE*AW-1:0]   wr_addr,
  input  logic [NUM_WRITE*XLEN-1:0] wr_data,
  input  logic [NUM_WRITE-1:0]      wr_clr,
  input  logic                      claim_valid,
  input  logic [AW-1:0]             claim_rd,
  input  logic                      flush,
  output logic                      any_busy
);

  logic [XLEN-1:0]     r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] r_busy;
  logic                r_any_busy;
  logic [NUM_REGS-1:0] w_busy_nxt;

  // x0 and addresses past the last register never hold state
  function automatic logic f_ok(input logic [AW-1:0] a);
    return (a != '0) && (int'(a) < NUM_REGS);
  endfunction

  always_comb begin
    w_busy_nxt = r_busy;
    for (int p = 0; p < NUM_WRITE; p++) begin
      if (we[p] && wr_clr[p] && f_ok(wr_addr[p*AW +: AW]))
        w_busy_nxt[wr_addr[p*AW +: AW]] = 1'b0;
    end
    if (claim_valid && f_ok(claim_rd))
      w_busy_nxt[claim_rd] = 1'b1;
    if (flush)
      w_busy_nxt = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++)
        r_regs[r] <= '0;
      r_busy     <= '0;
      r_any_busy <= 1'b0;
    end else begin
      for (int p = 0; p < NUM_WRITE; p++) begin
        if (we[p] && f_ok(wr_addr[p*AW +: AW]))
          r_regs[wr_addr[p*AW +: AW]] <= wr_data[p*XLEN +: XLEN];
      end
      r_busy     <= w_busy_nxt;
      r_any_busy <= |w_busy_nxt;
    end
  end

  assign any_busy = r_any_busy;

  for (genvar gi = 0; gi < NUM_READ; gi++) begin : g_rd
    logic [AW-1:0]   w_a;
    logic            w_ok;
    logic [XLEN-1:0] w_d;
    logic            w_b;

    assign w_a  = rs_addr[gi*AW +: AW];
    assign w_ok = f_ok(w_a);

    always_comb begin
      w_d = w_ok ? r_regs[w_a] : '0;
      w_b = w_ok ? r_busy[w_a] : 1'b0;
`ifdef REGFILE_BYPASS_EN
      // later ports overwrite earlier matches, so the highest index wins
      for (int p = 0; p < NUM_WRITE; p++) begin
        if (w_ok && we[p] && wr_addr[p*AW +: AW] == w_a) begin
          w_d = wr_data[p*XLEN +: XLEN];
          w_b = wr_clr[p] ? 1'b0 : r_busy[w_a];
        end
      end
`endif
    end

    assign rs_data[gi*XLEN +: XLEN] = w_d;
    assign rs_busy[gi]              = w_b;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp with a spec-level model checked every cycle.
// Works in both the default and the REGFILE_BYPASS_EN build.
module tb_regfile_mp;
  localparam int XL = 32;
  localparam int NR = 16;
  localparam int NRD = 2;
  localparam int NW = 2;
  localparam int AW = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NRD*AW-1:0] rs_addr;
  logic [NRD*XL-1:0] rs_data;
  logic [NRD-1:0]    rs_busy;
  logic [NW-1:0]     we;
  logic [NW*AW-1:0]  wr_addr;
  logic [NW*XL-1:0]  wr_data;
  logic [NW-1:0]     wr_clr;
  logic              claim_valid;
  logic [AW-1:0]     claim_rd;
  logic              flush;
  logic              any_busy;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  logic [XL-1:0] m_regs [NR];
  bit            m_busy [NR];

  regfile_mp #(
    .XLEN(XL), .NUM_REGS(NR), .NUM_READ(NRD), .NUM_WRITE(NW)
  ) dut (
    .clk(clk), .rst(rst),
    .rs_addr(rs_addr), .rs_data(rs_data), .rs_busy(rs_busy),
    .we(we), .wr_addr(wr_addr), .wr_data(wr_data), .wr_clr(wr_clr),
    .claim_valid(claim_valid), .claim_rd(claim_rd),
    .flush(flush), .any_busy(any_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask

  // Model: architectural state updated once per edge from the rules.
  always @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NR; r++) begin
        m_regs[r] = '0;
        m_busy[r] = 1'b0;
      end
    end else begin
      bit clr [NR];
      for (int r = 0; r < NR; r++) clr[r] = 1'b0;
      for (int p = 0; p < NW; p++) begin
        int a;
        a = int'(wr_addr[p*AW +: AW]);
        if (we[p] && a != 0) begin
          m_regs[a] = wr_data[p*XL +: XL];
          if (wr_clr[p]) clr[a] = 1'b1;
        end
      end
      for (int r = 1; r < NR; r++) begin
        if (flush) m_busy[r] = 1'b0;
        else if (claim_valid && int'(claim_rd) == r) m_busy[r] = 1'b1;
        else if (clr[r]) m_busy[r] = 1'b0;
      end
    end
  end

  function automatic void exp_rd(input int a, output logic [XL-1:0] d,
                                 output bit b);
    d = (a == 0) ? '0 : m_regs[a];
    b = (a == 0) ? 1'b0 : m_busy[a];
`ifdef REGFILE_BYPASS_EN
    for (int p = 0; p < NW; p++) begin
      if (a != 0 && we[p] && int'(wr_addr[p*AW +: AW]) == a) begin
        d = wr_data[p*XL +: XL];
        b = wr_clr[p] ? 1'b0 : m_busy[a];
      end
    end
`endif
  endfunction

  function automatic bit m_any();
    bit o = 1'b0;
    for (int r = 0; r < NR; r++) o |= m_busy[r];
    return o;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < NRD; i++) begin
        logic [XL-1:0] d;
        bit b;
        exp_rd(int'(rs_addr[i*AW +: AW]), d, b);
        chk("cmp_data", rs_data[i*XL +: XL], d);
        chk("cmp_busy", {31'b0, rs_busy[i]}, {31'b0, b});
      end
      chk("cmp_any", {31'b0, any_busy}, {31'b0, m_any()});
    end
  end

  task automatic idle();
    rst = 1'b0; we = '0; wr_clr = '0; wr_addr = '0; wr_data = '0;
    claim_valid = 1'b0; claim_rd = '0; flush = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int p, input int a, input logic [31:0] d,
                    input bit c);
    we[p] = 1'b1;
    wr_addr[p*AW +: AW] = AW'(a);
    wr_data[p*XL +: XL] = d;
    wr_clr[p] = c;
  endtask

  task automatic rd(input int a0, input int a1);
    rs_addr = {AW'(a1), AW'(a0)};
    #1;
  endtask

  initial begin
    idle();
    rs_addr = '0;
    rst = 1'b1;
    tick(); tick();
    chk_en = 1'b1;
    idle();

    // random writes and pending claims, then a two-cycle reset
    for (int r = 1; r < NR; r++) begin
      idle();
      wr(0, r, $urandom, 1'b0);
      claim_valid = 1'b1; claim_rd = AW'(r);
      tick();
    end
    idle();
    rst = 1'b1;
    tick(); tick();
    idle();
    for (int a = 0; a < NR; a++) begin
      rd(a, a);
      chk("rst_data", rs_data[31:0], 32'h0);
      chk("rst_busy", {30'b0, rs_busy}, 32'h0);
    end
    chk("rst_any", {31'b0, any_busy}, 32'h0);

    // basic write/read and x0
    wr(0, 5, 32'hDEADBEEF, 1'b0);
    tick(); idle();
    rd(5, 0);
    chk("wr_x5", rs_data[31:0], 32'hDEADBEEF);
    chk("rd_x0", rs_data[63:32], 32'h0);
    wr(0, 0, 32'h1234, 1'b0);
    tick(); idle();
    rd(0, 5);
    chk("wr_x0", rs_data[31:0], 32'h0);

    // scoreboard claim then clearing write
    claim_valid = 1'b1; claim_rd = 4'd7;
    tick(); idle();
    rd(7, 0);
    chk("claim_busy", {31'b0, rs_busy[0]}, 32'h1);
    chk("claim_any", {31'b0, any_busy}, 32'h1);
    claim_valid = 1'b1; claim_rd = 4'd7;
    tick(); idle();
    wr(0, 7, 32'h55, 1'b1);
    tick(); idle();
    rd(7, 0);
    chk("clr_busy", {31'b0, rs_busy[0]}, 32'h0);
    chk("clr_data", rs_data[31:0], 32'h55);

    // claim wins over same-cycle clear
    claim_valid = 1'b1; claim_rd = 4'd3;
    wr(0, 3, 32'hAA, 1'b1);
    tick(); idle();
    rd(3, 0);
    chk("coll_busy", {31'b0, rs_busy[0]}, 32'h1);
    chk("coll_data", rs_data[31:0], 32'hAA);

    // flush beats claim
    for (int r = 1; r <= 4; r = r * 2) begin
      claim_valid = 1'b1; claim_rd = AW'(r);
      tick(); idle();
    end
    flush = 1'b1; claim_valid = 1'b1; claim_rd = 4'd9;
    tick(); idle();
    rd(9, 4);
    chk("fl_any", {31'b0, any_busy}, 32'h0);
    chk("fl_x9", {31'b0, rs_busy[0]}, 32'h0);
    chk("fl_x4", {31'b0, rs_busy[1]}, 32'h0);
    rd(5, 3);
    chk("fl_data", rs_data[31:0], 32'hDEADBEEF);

    // two ports to one register: high port data, any clear wins
    claim_valid = 1'b1; claim_rd = 4'd8;
    tick(); idle();
    wr(0, 8, 32'h1, 1'b1);
    wr(1, 8, 32'h2, 1'b0);
    tick(); idle();
    rd(8, 0);
    chk("mp_data", rs_data[31:0], 32'h2);
    chk("mp_busy", {31'b0, rs_busy[0]}, 32'h0);

    // same-cycle write while reading: bypass dependent
    wr(0, 6, 32'h11, 1'b0);
    tick(); idle();
    claim_valid = 1'b1; claim_rd = 4'd6;
    tick(); idle();
    wr(1, 6, 32'h99, 1'b1);
    rd(6, 0);
`ifdef REGFILE_BYPASS_EN
    chk("byp_data", rs_data[31:0], 32'h99);
    chk("byp_busy", {31'b0, rs_busy[0]}, 32'h0);
`else
    chk("byp_data", rs_data[31:0], 32'h11);
    chk("byp_busy", {31'b0, rs_busy[0]}, 32'h1);
`endif
    tick(); idle();
    rd(6, 0);
    chk("post_data", rs_data[31:0], 32'h99);
    chk("post_busy", {31'b0, rs_busy[0]}, 32'h0);

    // reset discards pending claims
    claim_valid = 1'b1; claim_rd = 4'd10;
    tick(); idle();
    rst = 1'b1; claim_valid = 1'b1; claim_rd = 4'd11;
    tick(); idle();
    rd(10, 11);
    chk("rst_mid", {30'b0, rs_busy}, 32'h0);
    chk("rst_mid_any", {31'b0, any_busy}, 32'h0);

    tick();
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
